// File: rtl/ysyx_25070198_bus_pkg.sv
// Shared SimpleBus types for the SRAM responder: FSM states, request bundle,
// LFSR taps and the byte-merge used on masked writes.
package ysyx_25070198_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } sram_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } bus_req_t;

    // Right-shifting Galois form of x^8 + x^6 + x^5 + x^4 + 1
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {1'b0, s[7:1]} ^ (s[0] ? LFSR_TAPS : 8'h00);
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_25070198_sram_resp_if.sv
// LSU request/response bundle; the LSU drives the master side, the SRAM
// responder sits on the slave side.
interface ysyx_25070198_sram_resp_if;

    logic        reqValid;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic        respValid;
    logic        respErr;

    modport master (
        output reqValid, addr, wen, wdata, wmask,
        input  rdata, respValid, respErr
    );

    modport slave (
        input  reqValid, addr, wen, wdata, wmask,
        output rdata, respValid, respErr
    );

endinterface

// File: rtl/ysyx_25070198_lfsr8.sv
// Free-running 8-bit Galois LFSR; advances every cycle and reloads its seed on reset.
module ysyx_25070198_lfsr8
    import ysyx_25070198_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    output logic [7:0] out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= seed;
        end else begin
            out <= lfsr_next(out);
        end
    end

endmodule

// File: rtl/ysyx_25070198_sram_resp.sv
// SimpleBus responder backed by an internal word array, with a fixed or
// LFSR-driven request-to-response delay for latency-stress builds.
module ysyx_25070198_sram_resp
    import ysyx_25070198_bus_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          FIXED_LAT = 1,
    parameter int          RAND_EN   = 0,
    parameter logic [7:0]  LFSR_SEED = 8'hA5,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input logic                     clk,
    input logic                     rst,
    ysyx_25070198_sram_resp_if.slave lsu
);

    localparam int          IDX_W   = $clog2(DEPTH);
    localparam int          MAX_LAT = (FIXED_LAT > 8) ? FIXED_LAT : 8;
    localparam int          CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [32:0] SPAN    = 33'(DEPTH) << 2;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    sram_state_t      state;
    sram_state_t      next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] delay;
    logic [7:0]       lfsr;

    bus_req_t    req_in;
    bus_req_t    req_q;
    bus_req_t    cur_req;
    logic [31:0] cur_off;
    logic [31:0] resp_off;
    logic        cur_ok;
    logic        resp_ok;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] resp_idx;

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;
    logic        unused_lfsr;

    ysyx_25070198_lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .out  (lfsr)
    );

    assign unused_lfsr = ^lfsr[7:3];

    assign req_in = {lsu.addr, lsu.wen, lsu.wdata, lsu.wmask};
    assign delay  = (RAND_EN != 0) ? CNT_W'({1'b0, lfsr[2:0]} + 4'd1) : CNT_W'(FIXED_LAT);

    // In IDLE the transaction being decided is the one on the bus; afterwards it is the latched copy
    assign cur_req  = (state == IDLE) ? req_in : req_q;
    assign cur_off  = cur_req.addr - BASE_ADDR;
    assign resp_off = req_q.addr - BASE_ADDR;
    assign cur_ok   = {1'b0, cur_off} < SPAN;
    assign resp_ok  = {1'b0, resp_off} < SPAN;
    assign cur_idx  = cur_off[IDX_W+1:2];
    assign resp_idx = resp_off[IDX_W+1:2];

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (lsu.reqValid) begin
                    if (delay == ONE) begin
                        next_state = RESP;
                    end else begin
                        next_state = BUSY;
                        cnt_next   = delay - ONE;
                    end
                end
            end
            BUSY: begin
                if (cnt == ONE) begin
                    next_state = RESP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - ONE;
                end
            end
            RESP: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
            default: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            if (state == IDLE && lsu.reqValid) begin
                req_q <= req_in;
            end
            if (next_state == RESP) begin
                rdata_q <= (cur_req.wen || !cur_ok) ? 32'h0 : mem[cur_idx];
            end
        end
    end

    // Commit on the edge leaving RESP so a following read already sees the data
    always_ff @(posedge clk) begin
        if (!rst && state == RESP && req_q.wen && resp_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (req_q.wmask[b]) begin
                    mem[resp_idx][8*b +: 8] <= req_q.wdata[8*b +: 8];
                end
            end
        end
    end

    assign lsu.rdata     = rdata_q;
    assign lsu.respValid = (state == RESP);
    assign lsu.respErr   = (state == RESP) && !resp_ok;

endmodule

// File: tb/tb_ysyx_25070198_sram_resp.sv
// Four responder configurations driven from one shared initiator; expected
// responses are queued at drive time and checked when respValid arrives.
module tb_ysyx_25070198_sram_resp;
    import ysyx_25070198_bus_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    int          sel;

    logic [31:0] obs_rdata;
    logic        obs_valid;
    logic        obs_err;

    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];
    logic [31:0] model [bit [31:0]];
    logic [31:0] last_rdata;
    bit   [8:0]  seen_lat;

    always #5 clk = ~clk;

    ysyx_25070198_sram_resp_if if1 ();
    ysyx_25070198_sram_resp_if if3 ();
    ysyx_25070198_sram_resp_if if4 ();
    ysyx_25070198_sram_resp_if ifr ();

    assign if1.reqValid = req_valid && (sel == 0);
    assign if3.reqValid = req_valid && (sel == 1);
    assign if4.reqValid = req_valid && (sel == 2);
    assign ifr.reqValid = req_valid && (sel == 3);
    assign if1.addr = req_addr;  assign if1.wen = req_wen;  assign if1.wdata = req_wdata;  assign if1.wmask = req_wmask;
    assign if3.addr = req_addr;  assign if3.wen = req_wen;  assign if3.wdata = req_wdata;  assign if3.wmask = req_wmask;
    assign if4.addr = req_addr;  assign if4.wen = req_wen;  assign if4.wdata = req_wdata;  assign if4.wmask = req_wmask;
    assign ifr.addr = req_addr;  assign ifr.wen = req_wen;  assign ifr.wdata = req_wdata;  assign ifr.wmask = req_wmask;

    ysyx_25070198_sram_resp #(.FIXED_LAT(1)) dut1 (.clk(clk), .rst(rst), .lsu(if1));
    ysyx_25070198_sram_resp #(.FIXED_LAT(3)) dut3 (.clk(clk), .rst(rst), .lsu(if3));
    ysyx_25070198_sram_resp #(.FIXED_LAT(4)) dut4 (.clk(clk), .rst(rst), .lsu(if4));
    ysyx_25070198_sram_resp #(.RAND_EN(1))   dutr (.clk(clk), .rst(rst), .lsu(ifr));

    always_comb begin
        obs_rdata = '0;
        obs_valid = 1'b0;
        obs_err   = 1'b0;
        case (sel)
            0: begin obs_rdata = if1.rdata; obs_valid = if1.respValid; obs_err = if1.respErr; end
            1: begin obs_rdata = if3.rdata; obs_valid = if3.respValid; obs_err = if3.respErr; end
            2: begin obs_rdata = if4.rdata; obs_valid = if4.respValid; obs_err = if4.respErr; end
            3: begin obs_rdata = ifr.rdata; obs_valid = ifr.respValid; obs_err = ifr.respErr; end
            default: ;
        endcase
    end

    function automatic bit addr_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'h8000_0000;
        return off < 32'd4096;
    endfunction

    function automatic bit [31:0] mkey(input int dsel, input logic [31:0] a);
        return {dsel[1:0], a[31:2]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One full transaction; returns at a falling edge with the responder back in IDLE
    task automatic applyStimulus(input int dsel, input logic [31:0] a, input logic w,
                                 input logic [31:0] wd, input logic [3:0] wm,
                                 input int exp_lat, input bit hold, input bit drop);
        exp_t        e;
        exp_t        got;
        int          lat;
        bit          seen;
        logic [31:0] old;
        e.err = !addr_ok(a);
        e.lat = exp_lat;
        if (w || e.err) begin
            e.rdata = '0;
        end else begin
            e.rdata = model.exists(mkey(dsel, a)) ? model[mkey(dsel, a)] : 32'h0;
        end
        if (w && !e.err) begin
            old = model.exists(mkey(dsel, a)) ? model[mkey(dsel, a)] : 32'h0;
            model[mkey(dsel, a)] = byte_merge(old, wd, wm);
        end
        sb.push_back(e);
        sel       = dsel;
        req_addr  = a;
        req_wen   = w;
        req_wdata = wd;
        req_wmask = wm;
        req_valid = 1'b1;
        @(posedge clk);
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (obs_valid) begin
                seen = 1'b1;
                lat  = k;
            end else if (drop && k == 1) begin
                req_valid = 1'b0;
                req_addr  = 32'h8000_0FF0;
                req_wen   = 1'b0;
                req_wdata = 32'h0;
                req_wmask = 4'h0;
            end
        end
        checkOutput("resp_seen", 32'(seen), 32'd1);
        got = sb.pop_front();
        if (seen) begin
            checkOutput("rdata", obs_rdata, got.rdata);
            checkOutput("resp_err", 32'(obs_err), 32'(got.err));
            if (got.lat != 0) begin
                checkOutput("latency", lat, got.lat);
            end else begin
                checkOutput("lat_range", 32'(lat >= 1 && lat <= 8), 32'd1);
                if (lat >= 1 && lat <= 8) seen_lat[lat] = 1'b1;
            end
            last_rdata = obs_rdata;
            if (!hold) req_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            checkOutput("single_pulse", 32'(obs_valid), 32'd0);
        end else begin
            req_valid = 1'b0;
        end
    endtask

    initial begin
        int pulses;
        int distinct;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wen   = 1'b0;
        req_wdata = '0;
        req_wmask = '0;
        sel       = 0;
        seen_lat  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            checkOutput("reset_valid", 32'(obs_valid), 32'd0);
            checkOutput("reset_err", 32'(obs_err), 32'd0);
            checkOutput("reset_rdata", obs_rdata, 32'h0);
        end
        @(negedge clk);

        $display("[TB] single-cycle write then read");
        applyStimulus(0, 32'h8000_0010, 1'b1, 32'hDEADBEEF, 4'hF, 1, 0, 0);
        applyStimulus(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 1, 0, 0);
        checkOutput("raw_data", last_rdata, 32'hDEADBEEF);

        $display("[TB] byte-masked write");
        applyStimulus(1, 32'h8000_0020, 1'b1, 32'h11223344, 4'hF, 3, 0, 0);
        applyStimulus(1, 32'h8000_0020, 1'b1, 32'hAABBCCDD, 4'b0101, 3, 0, 0);
        applyStimulus(1, 32'h8000_0020, 1'b0, 32'h0, 4'h0, 3, 0, 0);
        checkOutput("mask_data", last_rdata, 32'h11BB33DD);

        $display("[TB] out-of-range accesses");
        applyStimulus(0, 32'h8000_0FFC, 1'b1, 32'h5A5A5A5A, 4'hF, 1, 0, 0);
        applyStimulus(0, 32'h8000_1000, 1'b0, 32'h0, 4'h0, 1, 0, 0);
        applyStimulus(0, 32'h7FFF_FFFC, 1'b1, 32'hFFFFFFFF, 4'hF, 1, 0, 0);
        applyStimulus(0, 32'h8000_0FFC, 1'b0, 32'h0, 4'h0, 1, 0, 0);
        checkOutput("oor_mem_kept", last_rdata, 32'h5A5A5A5A);

        $display("[TB] random latency back-to-back reads");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3, 32'h8000_0100 + 32'(4 * i), 1'b1, 32'hA000_0000 + 32'(i), 4'hF, 0, 0, 0);
        end
        for (int i = 0; i < 200; i++) begin
            applyStimulus(3, 32'h8000_0100 + 32'(4 * $urandom_range(0, 3)), 1'b0, 32'h0, 4'h0, 0, 1, 0);
        end
        req_valid = 1'b0;
        distinct = 0;
        for (int l = 1; l <= 8; l++) distinct += int'(seen_lat[l]);
        checkOutput("distinct_lat", 32'(distinct >= 4), 32'd1);

        $display("[TB] reset during busy");
        applyStimulus(2, 32'h8000_0000, 1'b1, 32'h12345678, 4'hF, 4, 0, 0);
        sel       = 2;
        req_addr  = 32'h8000_0000;
        req_wen   = 1'b1;
        req_wdata = 32'hCAFEF00D;
        req_wmask = 4'hF;
        req_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("valid_after_reset", 32'(obs_valid), 32'd0);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (obs_valid) pulses++;
        end
        checkOutput("abandoned_pulses", pulses, 0);
        applyStimulus(2, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 4, 0, 0);
        checkOutput("abandoned_no_commit", last_rdata, 32'h12345678);

        $display("[TB] initiator drops reqValid while busy");
        applyStimulus(1, 32'h8000_0004, 1'b1, 32'h0000_00FF, 4'hF, 3, 0, 1);
        applyStimulus(1, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 3, 0, 0);
        checkOutput("drop_data", last_rdata, 32'h0000_00FF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
